// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I shared decode types: opcodes, ALU ops, immediate and result selects.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    // Coarse ALU intent from the main decoder, refined by funct3/funct7
    typedef enum logic [2:0] {
        AOP_ADD, AOP_SUB, AOP_FUNCT_R, AOP_FUNCT_I, AOP_PASSB
    } alu_op_t;

endpackage

// File: rtl/decode_stage_reg_file.sv
// rtl/decode_stage_reg_file.sv - 32-entry register file with async clear, hardwired x0 and write-through reads.
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             wr_en;

    assign wr_en = we && (waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass stays live during reset; downstream is held in reset too
    always_comb begin
        rdata1 = regs_q[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (wr_en && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = regs_q[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (wr_en && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: main/ALU decoders, immediate extender and register file.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      instr_D,
    input  logic [WIDTH-1:0]      PC_D,
    input  logic [WIDTH-1:0]      PCPlus4_D,
    input  logic                  RegWrite_W,
    input  logic [REG_ADDR_W-1:0] Rd_W,
    input  logic [WIDTH-1:0]      Result_W,
    output logic [WIDTH-1:0]      RD1_D,
    output logic [WIDTH-1:0]      RD2_D,
    output logic [WIDTH-1:0]      ImmExt_D,
    output logic [REG_ADDR_W-1:0] Rs1_D,
    output logic [REG_ADDR_W-1:0] Rs2_D,
    output logic [REG_ADDR_W-1:0] Rd_D,
    output logic [2:0]            Funct3_D,
    output logic                  RegWrite_D,
    output logic                  MemWrite_D,
    output logic                  Jump_D,
    output logic                  Branch_D,
    output logic                  Jalr_D,
    output logic [1:0]            ResultSrc_D,
    output logic                  ALUSrcA_D,
    output logic                  ALUSrcB_D,
    output logic [3:0]            ALUControl_D,
    output logic                  Illegal_D,
    output logic [WIDTH-1:0]      PC_Dout,
    output logic [WIDTH-1:0]      PCPlus4_Dout
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        reg_write, mem_write, jump, branch, jalr, alu_src_a, alu_src_b;
    logic        class_bad, funct_bad, illegal;
    logic        is_r, f7_base, f7_alt;
    result_src_t result_src;
    alu_op_t     alu_op;
    alu_ctrl_t   alu_ctrl;
    imm_src_t    imm_src;

    assign opcode       = instr_D[6:0];
    assign funct3       = instr_D[14:12];
    assign funct7       = instr_D[31:25];
    assign Rs1_D        = instr_D[19:15];
    assign Rs2_D        = instr_D[24:20];
    assign Rd_D         = instr_D[11:7];
    assign Funct3_D     = funct3;
    assign PC_Dout      = PC_D;
    assign PCPlus4_Dout = PCPlus4_D;

    reg_file #(.WIDTH(WIDTH), .ADDR_W(REG_ADDR_W)) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .we     (RegWrite_W),
        .waddr  (Rd_W),
        .wdata  (Result_W),
        .raddr1 (Rs1_D),
        .raddr2 (Rs2_D),
        .rdata1 (RD1_D),
        .rdata2 (RD2_D)
    );

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        jalr       = 1'b0;
        result_src = RES_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = AOP_ADD;
        imm_src    = IMM_NONE;
        class_bad  = 1'b0;
        case (opcode)
            OP_LOAD: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                alu_src_b  = 1'b1;
                imm_src    = IMM_I;
                class_bad  = funct3 != 3'b010;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src_b = 1'b1;
                imm_src   = IMM_S;
                class_bad = funct3 != 3'b010;
            end
            OP_RTYPE: begin
                reg_write = 1'b1;
                alu_op    = AOP_FUNCT_R;
            end
            OP_ITYPE: begin
                reg_write = 1'b1;
                alu_src_b = 1'b1;
                alu_op    = AOP_FUNCT_I;
                imm_src   = IMM_I;
            end
            OP_BRANCH: begin
                branch    = 1'b1;
                alu_op    = AOP_SUB;
                imm_src   = IMM_B;
                class_bad = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL: begin
                jump       = 1'b1;
                reg_write  = 1'b1;
                result_src = RES_PC4;
                imm_src    = IMM_J;
            end
            OP_JALR: begin
                jump       = 1'b1;
                jalr       = 1'b1;
                reg_write  = 1'b1;
                result_src = RES_PC4;
                alu_src_b  = 1'b1;
                imm_src    = IMM_I;
                class_bad  = funct3 != 3'b000;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src_b = 1'b1;
                alu_op    = AOP_PASSB;
                imm_src   = IMM_U;
            end
            OP_AUIPC: begin
                reg_write = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = 1'b1;
                imm_src   = IMM_U;
            end
            default: class_bad = instr_D != '0;
        endcase
    end

    // funct7 must be all-zero except the SUB/SRA alternate forms
    always_comb begin
        alu_ctrl  = ALU_ADD;
        funct_bad = 1'b0;
        is_r      = alu_op == AOP_FUNCT_R;
        f7_base   = funct7 == F7_BASE;
        f7_alt    = funct7 == F7_ALT;
        case (alu_op)
            AOP_SUB:   alu_ctrl = ALU_SUB;
            AOP_PASSB: alu_ctrl = ALU_PASSB;
            AOP_FUNCT_R, AOP_FUNCT_I: begin
                case (funct3)
                    3'b000: begin
                        alu_ctrl  = (is_r && f7_alt) ? ALU_SUB : ALU_ADD;
                        funct_bad = is_r && !(f7_base || f7_alt);
                    end
                    3'b001: begin
                        alu_ctrl  = ALU_SLL;
                        funct_bad = !f7_base;
                    end
                    3'b101: begin
                        alu_ctrl  = f7_alt ? ALU_SRA : ALU_SRL;
                        funct_bad = !(f7_base || f7_alt);
                    end
                    default: begin
                        funct_bad = is_r && !f7_base;
                        case (funct3)
                            3'b010:  alu_ctrl = ALU_SLT;
                            3'b011:  alu_ctrl = ALU_SLTU;
                            3'b100:  alu_ctrl = ALU_XOR;
                            3'b110:  alu_ctrl = ALU_OR;
                            default: alu_ctrl = ALU_AND;
                        endcase
                    end
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        case (imm_src)
            IMM_I:   ImmExt_D = {{(WIDTH-12){instr_D[31]}}, instr_D[31:20]};
            IMM_S:   ImmExt_D = {{(WIDTH-12){instr_D[31]}}, instr_D[31:25], instr_D[11:7]};
            IMM_B:   ImmExt_D = {{(WIDTH-13){instr_D[31]}}, instr_D[31], instr_D[7],
                                 instr_D[30:25], instr_D[11:8], 1'b0};
            IMM_U:   ImmExt_D = {instr_D[31:12], 12'b0};
            IMM_J:   ImmExt_D = {{(WIDTH-21){instr_D[31]}}, instr_D[31], instr_D[19:12],
                                 instr_D[20], instr_D[30:21], 1'b0};
            default: ImmExt_D = '0;
        endcase
    end

    always_comb begin
        illegal      = class_bad || funct_bad;
        Illegal_D    = illegal;
        RegWrite_D   = reg_write && !illegal;
        MemWrite_D   = mem_write && !illegal;
        Jump_D       = jump && !illegal;
        Branch_D     = branch && !illegal;
        Jalr_D       = jalr && !illegal;
        ResultSrc_D  = illegal ? 2'b00 : result_src;
        ALUSrcA_D    = alu_src_a && !illegal;
        ALUSrcB_D    = alu_src_b && !illegal;
        ALUControl_D = illegal ? 4'd0 : alu_ctrl;
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - Self-checking bench for decode_stage with a behavioural decode and register model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_D, PC_D, PCPlus4_D, Result_W;
    logic        RegWrite_W;
    logic [4:0]  Rd_W;
    logic [31:0] RD1_D, RD2_D, ImmExt_D, PC_Dout, PCPlus4_Dout;
    logic [4:0]  Rs1_D, Rs2_D, Rd_D;
    logic [2:0]  Funct3_D;
    logic        RegWrite_D, MemWrite_D, Jump_D, Branch_D, Jalr_D, ALUSrcA_D, ALUSrcB_D, Illegal_D;
    logic [1:0]  ResultSrc_D;
    logic [3:0]  ALUControl_D;

    logic [13:0]  ctl_obs;
    logic [191:0] all_out;
    logic [31:0]  model [32];
    int n_cmp = 0;
    int n_bad = 0;

    assign ctl_obs = {RegWrite_D, MemWrite_D, Jump_D, Branch_D, Jalr_D, ResultSrc_D,
                      ALUSrcA_D, ALUSrcB_D, ALUControl_D, Illegal_D};
    assign all_out = {RD1_D, RD2_D, ImmExt_D, Rs1_D, Rs2_D, Rd_D, Funct3_D, ctl_obs,
                      PC_Dout, PCPlus4_Dout};

    always #5 clk = ~clk;

    decode_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .instr_D(instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
        .RegWrite_W(RegWrite_W), .Rd_W(Rd_W), .Result_W(Result_W),
        .RD1_D(RD1_D), .RD2_D(RD2_D), .ImmExt_D(ImmExt_D),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D), .Funct3_D(Funct3_D),
        .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D), .Jump_D(Jump_D),
        .Branch_D(Branch_D), .Jalr_D(Jalr_D), .ResultSrc_D(ResultSrc_D),
        .ALUSrcA_D(ALUSrcA_D), .ALUSrcB_D(ALUSrcB_D), .ALUControl_D(ALUControl_D),
        .Illegal_D(Illegal_D), .PC_Dout(PC_Dout), .PCPlus4_Dout(PCPlus4_Dout)
    );

    // control vector: {rw, mw, jump, branch, jalr, res[1:0], srcA, srcB, alu[3:0], illegal}
    localparam logic [31:0] DIR_INS [10] = '{
        32'hFFF00093, 32'hFE000EE3, 32'h008000EF, 32'h123450B7, 32'hFFFFF117,
        32'hFFE280E7, 32'hFE512C23, 32'h00402183, 32'h40000033, 32'h4030D093};
    localparam logic [13:0] DIR_CTL [10] = '{
        14'b10000_00_01_0000_0, 14'b00010_00_00_0001_0, 14'b10100_10_00_0000_0,
        14'b10000_00_01_1010_0, 14'b10000_00_11_0000_0, 14'b10101_10_01_0000_0,
        14'b01000_00_01_0000_0, 14'b10000_01_01_0000_0, 14'b10000_00_00_0001_0,
        14'b10000_00_01_1001_0};
    localparam logic [31:0] DIR_IMM [10] = '{
        32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h12345000, 32'hFFFFF000,
        32'hFFFFFFFE, 32'hFFFFFFF8, 32'h00000004, 32'h00000000, 32'h00000403};
    localparam logic [31:0] BAD_INS [8] = '{
        32'h0000007F, 32'h00003003, 32'h02000033, 32'h40001033,
        32'h00002063, 32'h00001067, 32'h40001013, 32'h40002033};

    function automatic logic [13:0] exp_ctl(input logic [31:0] ins);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic rw = 0, mw = 0, j = 0, b = 0, jr = 0, sa = 0, sb = 0, ok = 1;
        logic [1:0] rs = 0;
        logic [3:0] alu = 0;
        case (op)
            7'h03: begin ok = (f3 == 2); rw = 1; rs = 1; sb = 1; end
            7'h23: begin ok = (f3 == 2); mw = 1; sb = 1; end
            7'h33, 7'h13: begin
                rw = 1;
                sb = (op == 7'h13);
                case (f3)
                    0: alu = 0;  1: alu = 7;  2: alu = 5;  3: alu = 6;
                    4: alu = 4;  5: alu = 8;  6: alu = 3;  default: alu = 2;
                endcase
                if (f7 == 7'h20 && f3 == 5) alu = 9;
                if (f7 == 7'h20 && f3 == 0 && op == 7'h33) alu = 1;
                if (op == 7'h33) ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                else ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
            end
            7'h63: begin ok = (f3 != 2 && f3 != 3); b = 1; alu = 1; end
            7'h6F: begin j = 1; rw = 1; rs = 2; end
            7'h67: begin ok = (f3 == 0); j = 1; jr = 1; rw = 1; rs = 2; sb = 1; end
            7'h37: begin rw = 1; sb = 1; alu = 10; end
            7'h17: begin rw = 1; sa = 1; sb = 1; end
            default: ok = (ins == 0);
        endcase
        if (!ok) return 14'b1;
        return {rw, mw, j, b, jr, rs, sa, sb, alu, 1'b0};
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] ins);
        int s, t;
        s = ins;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: begin t = s >>> 20; return t; end
            7'h23: begin t = s >>> 25; return (t << 5) | ((ins >> 7) & 31); end
            7'h63: begin
                t = s >>> 31;
                return (t << 12) | (((ins >> 7) & 1) << 11) | (((ins >> 25) & 63) << 5)
                       | (((ins >> 8) & 15) << 1);
            end
            7'h37, 7'h17: return ins & 32'hFFFFF000;
            7'h6F: begin
                t = s >>> 31;
                return (t << 20) | (((ins >> 12) & 255) << 12) | (((ins >> 20) & 1) << 11)
                       | (((ins >> 21) & 1023) << 1);
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (RegWrite_W && Rd_W != 0 && Rd_W == idx) return Result_W;
        return model[idx];
    endfunction

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
        @(negedge clk);
        RegWrite_W = 1'b1; Rd_W = rd; Result_W = val;
        @(posedge clk);
        if (rd != 0) model[rd] = val;
        #1 RegWrite_W = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_D = 0; PC_D = 0; PCPlus4_D = 0;
        RegWrite_W = 0; Rd_W = 0; Result_W = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ctl_obs !== 14'b0) begin
            n_bad++; $display("FAIL bubble_ctl: got %b want 0", ctl_obs);
        end
    endtask

    task automatic test_basic_rw();
        write_reg(5, 32'hDEADBEEF);
        @(negedge clk);
        instr_D = 32'h00028333;
        #1;
        n_cmp++;
        if (RD1_D !== 32'hDEADBEEF || RD2_D !== 32'h0) begin
            n_bad++; $display("FAIL basic_read: got %h/%h want deadbeef/0", RD1_D, RD2_D);
        end
        n_cmp++;
        if (RegWrite_D !== 1'b1 || ALUControl_D !== 4'd0 || Rd_D !== 5'd6 || Illegal_D !== 1'b0) begin
            n_bad++; $display("FAIL basic_ctl: got rw=%b alu=%0d rd=%0d ill=%b want 1/0/6/0",
                              RegWrite_D, ALUControl_D, Rd_D, Illegal_D);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        instr_D = 32'h00700433;
        RegWrite_W = 1; Rd_W = 7; Result_W = 32'h12345678;
        #1;
        n_cmp++;
        if (RD2_D !== 32'h12345678) begin
            n_bad++; $display("FAIL bypass_rd2: got %h want 12345678", RD2_D);
        end
        @(posedge clk);
        model[7] = 32'h12345678;
        #1 RegWrite_W = 0;
        #1;
        n_cmp++;
        if (RD2_D !== 32'h12345678) begin
            n_bad++; $display("FAIL array_rd2: got %h want 12345678", RD2_D);
        end
        @(negedge clk);
        instr_D = 32'h00000333;
        RegWrite_W = 1; Rd_W = 0; Result_W = 32'hFFFFFFFF;
        #1;
        n_cmp++;
        if (RD1_D !== 32'h0 || RD2_D !== 32'h0) begin
            n_bad++; $display("FAIL x0_bypass: got %h/%h want 0/0", RD1_D, RD2_D);
        end
        @(posedge clk);
        #1 RegWrite_W = 0;
        #1;
        n_cmp++;
        if (RD1_D !== 32'h0) begin
            n_bad++; $display("FAIL x0_write: got %h want 0", RD1_D);
        end
        @(negedge clk);
        instr_D = 32'h007381B3;  // add x3,x7,x7
        RegWrite_W = 1; Rd_W = 7; Result_W = 32'hCAFEF00D;
        #1;
        n_cmp++;
        if (RD1_D !== 32'hCAFEF00D || RD2_D !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL dual_bypass: got %h/%h want cafef00d", RD1_D, RD2_D);
        end
        @(posedge clk);
        model[7] = 32'hCAFEF00D;
        #1 RegWrite_W = 0;
    endtask

    task automatic test_immediates();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            instr_D = DIR_INS[i];
            #1;
            n_cmp++;
            if (ctl_obs !== DIR_CTL[i] || ImmExt_D !== DIR_IMM[i]) begin
                n_bad++;
                $display("FAIL imm_ctl[%0d] %h: got ctl=%b imm=%h want ctl=%b imm=%h",
                         i, DIR_INS[i], ctl_obs, ImmExt_D, DIR_CTL[i], DIR_IMM[i]);
            end
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            instr_D = BAD_INS[i];
            #1;
            n_cmp++;
            if (ctl_obs !== 14'b1) begin
                n_bad++; $display("FAIL illegal[%0d] %h: got ctl=%b want only illegal", i, BAD_INS[i], ctl_obs);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [6:0]  ops [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0: ins[31:25] = 7'h00;
                1: ins[31:25] = 7'h20;
                default: ;
            endcase
            instr_D = ins;
            PC_D = $urandom; PCPlus4_D = PC_D + 4;
            RegWrite_W = $urandom_range(0, 1); Rd_W = $urandom; Result_W = $urandom;
            #1;
            n_cmp++;
            if (ctl_obs !== exp_ctl(ins) || ImmExt_D !== exp_imm(ins)) begin
                n_bad++; $display("FAIL rand_decode %h: got ctl=%b imm=%h want ctl=%b imm=%h",
                                  ins, ctl_obs, ImmExt_D, exp_ctl(ins), exp_imm(ins));
            end
            n_cmp++;
            if (RD1_D !== exp_rd(ins[19:15]) || RD2_D !== exp_rd(ins[24:20])) begin
                n_bad++; $display("FAIL rand_read %h: got %h/%h want %h/%h", ins, RD1_D, RD2_D,
                                  exp_rd(ins[19:15]), exp_rd(ins[24:20]));
            end
            n_cmp++;
            if ({Rs1_D, Rs2_D, Rd_D, Funct3_D, PC_Dout, PCPlus4_Dout} !==
                {ins[19:15], ins[24:20], ins[11:7], ins[14:12], PC_D, PC_D + 32'd4}) begin
                n_bad++; $display("FAIL rand_fields %h: got rs1=%0d rs2=%0d rd=%0d f3=%0d pc=%h",
                                  ins, Rs1_D, Rs2_D, Rd_D, Funct3_D, PC_Dout);
            end
            @(posedge clk);
            if (RegWrite_W && Rd_W != 0) model[Rd_W] = Result_W;
        end
        #1 RegWrite_W = 0;
    endtask

    task automatic test_async_reset();
        write_reg(9, 32'hA5A5A5A5);
        @(negedge clk);
        instr_D = 32'h000480B3;
        #1;
        n_cmp++;
        if (RD1_D !== 32'hA5A5A5A5) begin
            n_bad++; $display("FAIL pre_reset_read: got %h want a5a5a5a5", RD1_D);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (RD1_D !== 32'h0) begin
            n_bad++; $display("FAIL async_clear: got %h want 0", RD1_D);
        end
        RegWrite_W = 1; Rd_W = 9; Result_W = 32'h5555AAAA;
        #1;
        n_cmp++;
        if (RD1_D !== 32'h5555AAAA) begin
            n_bad++; $display("FAIL reset_bypass: got %h want 5555aaaa", RD1_D);
        end
        @(posedge clk);
        #1 RegWrite_W = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        n_cmp++;
        if (RD1_D !== 32'h0) begin
            n_bad++; $display("FAIL reset_blocks_write: got %h want 0", RD1_D);
        end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_bypass();
        test_immediates();
        test_illegal();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
